eq_coef_loader: RTL and testbench
=================================

EQ_COEF_LOADER -- requirements
Module: eq_coef_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, coefficient address width (1024 coefficients per bank).
REQ-002 The block SHALL have parameter COEF_W, default 16, coefficient data width; COEF_W SHALL be <= 16.
REQ-003 The block SHALL have port user_clk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port user_rst_n, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port ctl_in, input, 32, the software control word from the register block:
- [31] wr strobe
- [30] fill
- [29] commit
- [16+ADDR_W-1:16] addr
- [COEF_W-1:0] coef
REQ-006 The block SHALL have port sync_in, input, 1, the datapath frame sync pulse.
REQ-007 The block SHALL have port coef_we, output, 1, the coefficient RAM write enable.
REQ-008 The block SHALL have port coef_addr, output, ADDR_W, the coefficient RAM write address.
REQ-009 The block SHALL have port coef_data, output, COEF_W, the coefficient RAM write data.
REQ-010 The block SHALL have port coef_bank, output, 1, the bank being written; it always equals ~active_bank.
REQ-011 The block SHALL have port active_bank, output, 1, the bank read by the datapath.
REQ-012 The block SHALL have port busy, output, 1, high while in WRITE or FILL, or while a commit is pending.
REQ-013 The block SHALL have port cmd_count, output, 16, the number of completed write/fill commands.

Function
REQ-014 ctl_in SHALL be registered twice (ctl_q, ctl_q2); an edge SHALL be detected as ctl_q[b] & ~ctl_q2[b].
REQ-015 addr, coef and fill SHALL be captured from ctl_q in the cycle the wr edge is detected.
REQ-016 The FSM SHALL have states IDLE, WRITE and FILL.
REQ-017 In IDLE, a wr edge with fill=0 SHALL go to WRITE; a wr edge with fill=1 SHALL go to FILL.
REQ-018 WRITE SHALL last exactly 1 cycle:
- coef_we=1, coef_addr=captured addr, coef_data=captured coef;
- then return to IDLE.
REQ-019 FILL SHALL last exactly 2^ADDR_W cycles:
- coef_we=1 every cycle;
- coef_addr=0,1,...,2^ADDR_W-1;
- coef_data=captured coef;
- then return to IDLE.
REQ-020 Latency SHALL be fixed: coef_we first asserts 3 user_clk cycles after the cycle ctl_in[31] first reads 1.
REQ-021 A wr edge detected while in WRITE or FILL SHALL be ignored; it is not queued.
REQ-022 cmd_count SHALL increment by 1 on the last write cycle of each WRITE or FILL, and SHALL wrap from 0xFFFF to 0.
REQ-023 A commit edge in any state SHALL set commit_pending; a repeated commit edge while pending SHALL have no further effect.
REQ-024 When commit_pending=1, state=IDLE and sync_in=1, then on the next cycle:
- active_bank SHALL toggle;
- commit_pending SHALL clear.
REQ-025 sync_in while in WRITE or FILL SHALL NOT swap banks; the swap SHALL wait for the first sync_in seen in IDLE.
REQ-026 If a wr edge and sync_in (with commit pending) occur in the same IDLE cycle, the swap SHALL take effect and the write SHALL go to the new coef_bank.
REQ-027 Simultaneous wr and commit edges SHALL start the write and set commit_pending.
REQ-028 When coef_we=0, coef_addr and coef_data SHALL hold their last values.
REQ-029 busy SHALL be the registered value of (state!=IDLE) | commit_pending.

Reset
REQ-030 While user_rst_n=0 at a user_clk edge, the block SHALL:
- set state=IDLE, coef_we=0, coef_addr=0, coef_data=0;
- set active_bank=0, so coef_bank=1;
- clear commit_pending;
- set busy=0 and cmd_count=0;
- clear ctl_q and ctl_q2 to 0.
REQ-031 A reset asserted mid-FILL SHALL abort the fill immediately, with no cmd_count increment.
REQ-032 After reset release, a ctl_in[31] already high SHALL produce one wr edge, because ctl_q2 was cleared.

Verification
REQ-033 Single write: ctl_in=0x8005_1234 from 0x0 -> exactly one coef_we pulse, 3 cycles later, with addr=0x005, data=0x1234, coef_bank=1, cmd_count=1.
REQ-034 Fill: ctl_in=0xC000_00AA -> 1024 consecutive coef_we cycles, addr 0..1023, data=0x00AA; cmd_count+1; busy drops 1 cycle after the last write.
REQ-035 Commit and swap: commit edge, then sync_in after 10 cycles -> active_bank 0->1 one cycle after sync_in; busy low one cycle later; coef_bank=0.
REQ-036 Commit during fill: commit edge at fill address 100, sync_in at address 500 -> no swap; swap on the first sync_in after the fill completes.
REQ-037 Ignored strobe: a second wr edge at fill address 10 -> no extra writes; cmd_count increments once.
REQ-038 Reset mid-fill: user_rst_n=0 at fill address 300 -> next cycle coef_we=0, cmd_count=0, active_bank=0, busy=0.

Source files
------------

// File: rtl/eq_coef_loader.sv
// Double-buffered EQ coefficient loader: software writes or fills the shadow bank,
// and a committed bank swap is applied on the next frame sync seen while idle.
module eq_coef_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned COEF_W = 16
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctl_in,
    input  logic              sync_in,
    output logic              coef_we,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_bank,
    output logic              active_bank,
    output logic              busy,
    output logic [15:0]       cmd_count
);

    typedef enum logic [1:0] {StIdle, StWrite, StFill} state_e;

    state_e            state_q, state_d;
    logic [31:0]       ctl_q, ctl_q2;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COEF_W-1:0] coef_q, coef_d;
    logic [ADDR_W-1:0] fill_idx_q, fill_idx_d;
    logic              commit_pending_q, commit_pending_d;
    logic              active_bank_q, active_bank_d;
    logic              coef_we_q, coef_we_d;
    logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
    logic [COEF_W-1:0] coef_data_q, coef_data_d;
    logic              busy_q, busy_d;
    logic [15:0]       cmd_count_q, cmd_count_d;

    logic wr_edge, commit_edge, swap;

    always_comb begin
        wr_edge          = ctl_q[31] & ~ctl_q2[31];
        commit_edge      = ctl_q[29] & ~ctl_q2[29];
        swap             = commit_pending_q && (state_q == StIdle) && sync_in;

        state_d          = state_q;
        addr_d           = addr_q;
        coef_d           = coef_q;
        fill_idx_d       = fill_idx_q;
        coef_we_d        = 1'b0;
        coef_addr_d      = coef_addr_q;
        coef_data_d      = coef_data_q;
        cmd_count_d      = cmd_count_q;
        commit_pending_d = commit_pending_q;
        active_bank_d    = active_bank_q;
        busy_d           = (state_q != StIdle) | commit_pending_q;

        unique case (state_q)
            StIdle: begin
                if (wr_edge) begin
                    addr_d     = ctl_q[16 +: ADDR_W];
                    coef_d     = ctl_q[COEF_W-1:0];
                    fill_idx_d = '0;
                    state_d    = ctl_q[30] ? StFill : StWrite;
                end
            end
            StWrite: begin
                coef_we_d   = 1'b1;
                coef_addr_d = addr_q;
                coef_data_d = coef_q;
                cmd_count_d = cmd_count_q + 16'd1;
                state_d     = StIdle;
            end
            StFill: begin
                coef_we_d   = 1'b1;
                coef_addr_d = fill_idx_q;
                coef_data_d = coef_q;
                fill_idx_d  = fill_idx_q + 1'b1;
                if (fill_idx_q == {ADDR_W{1'b1}}) begin
                    cmd_count_d = cmd_count_q + 16'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A swap consumes the pending commit; a coincident commit edge is absorbed.
        if (swap) begin
            active_bank_d    = ~active_bank_q;
            commit_pending_d = 1'b0;
        end else if (commit_edge) begin
            commit_pending_d = 1'b1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q          <= StIdle;
            ctl_q            <= '0;
            ctl_q2           <= '0;
            addr_q           <= '0;
            coef_q           <= '0;
            fill_idx_q       <= '0;
            commit_pending_q <= 1'b0;
            active_bank_q    <= 1'b0;
            coef_we_q        <= 1'b0;
            coef_addr_q      <= '0;
            coef_data_q      <= '0;
            busy_q           <= 1'b0;
            cmd_count_q      <= '0;
        end else begin
            state_q          <= state_d;
            ctl_q            <= ctl_in;
            ctl_q2           <= ctl_q;
            addr_q           <= addr_d;
            coef_q           <= coef_d;
            fill_idx_q       <= fill_idx_d;
            commit_pending_q <= commit_pending_d;
            active_bank_q    <= active_bank_d;
            coef_we_q        <= coef_we_d;
            coef_addr_q      <= coef_addr_d;
            coef_data_q      <= coef_data_d;
            busy_q           <= busy_d;
            cmd_count_q      <= cmd_count_d;
        end
    end

    assign coef_we     = coef_we_q;
    assign coef_addr   = coef_addr_q;
    assign coef_data   = coef_data_q;
    assign active_bank = active_bank_q;
    assign coef_bank   = ~active_bank_q;
    assign busy        = busy_q;
    assign cmd_count   = cmd_count_q;

endmodule

// File: tb/tb_eq_coef_loader.sv
// Directed bench for eq_coef_loader: write, fill, ignored strobe, commit/swap timing
// and reset behaviour, with hand-computed expectations.
module tb_eq_coef_loader;

    logic        user_clk = 1'b0;
    logic        user_rst_n = 1'b0;
    logic [31:0] ctl_in = 32'h0;
    logic        sync_in = 1'b0;
    logic        coef_we;
    logic [9:0]  coef_addr;
    logic [15:0] coef_data;
    logic        coef_bank;
    logic        active_bank;
    logic        busy;
    logic [15:0] cmd_count;

    int total = 0;
    int bad = 0;

    eq_coef_loader #(.ADDR_W(10), .COEF_W(16)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctl_in     (ctl_in),
        .sync_in    (sync_in),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_bank  (coef_bank),
        .active_bank(active_bank),
        .busy       (busy),
        .cmd_count  (cmd_count)
    );

    always #5 user_clk = ~user_clk;

    // Advance n clock edges and settle just past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        user_rst_n = 1'b0;
        ctl_in = 32'h0;
        sync_in = 1'b0;
        tick(2);
        total++;
        if (coef_we !== 1'b0 || coef_addr !== 10'd0 || coef_data !== 16'd0) begin
            bad++;
            $display("FAIL reset_wr_port: we=%b addr=%h data=%h want 0 0 0",
                     coef_we, coef_addr, coef_data);
        end
        total++;
        if (active_bank !== 1'b0 || coef_bank !== 1'b1) begin
            bad++;
            $display("FAIL reset_bank: active=%b coef_bank=%b want 0 1", active_bank, coef_bank);
        end
        total++;
        if (busy !== 1'b0 || cmd_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_status: busy=%b cmd=%0d want 0 0", busy, cmd_count);
        end
        user_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_write();
        ctl_in = 32'h8005_1234;
        tick(2);
        total++;
        if (coef_we !== 1'b0) begin
            bad++;
            $display("FAIL write_early: we=%b at cycle 2 want 0", coef_we);
        end
        tick(1);
        total++;
        if (coef_we !== 1'b1 || coef_addr !== 10'h005 || coef_data !== 16'h1234
            || coef_bank !== 1'b1) begin
            bad++;
            $display("FAIL write_pulse: we=%b addr=%h data=%h bank=%b want 1 005 1234 1",
                     coef_we, coef_addr, coef_data, coef_bank);
        end
        total++;
        if (cmd_count !== 16'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL write_status: cmd=%0d busy=%b want 1 1", cmd_count, busy);
        end
        tick(1);
        total++;
        if (coef_we !== 1'b0 || coef_addr !== 10'h005 || coef_data !== 16'h1234
            || busy !== 1'b0) begin
            bad++;
            $display("FAIL write_hold: we=%b addr=%h data=%h busy=%b want 0 005 1234 0",
                     coef_we, coef_addr, coef_data, busy);
        end
        ctl_in = 32'h0;
        tick(4);
        total++;
        if (cmd_count !== 16'd1 || coef_we !== 1'b0) begin
            bad++;
            $display("FAIL write_once: cmd=%0d we=%b want 1 0", cmd_count, coef_we);
        end
    endtask

    // Full fill with a second strobe arriving around address 10.
    task automatic test_fill_ignored();
        int errs = 0;
        int first = -1;
        ctl_in = 32'hC000_00AA;
        tick(3);
        for (int i = 0; i < 1024; i++) begin
            if (i == 5) ctl_in = 32'h0;
            if (i == 8) ctl_in = 32'hC000_0055;
            if (coef_we !== 1'b1 || coef_addr !== i[9:0] || coef_data !== 16'h00AA
                || busy !== 1'b1) begin
                errs++;
                if (first < 0) first = i;
            end
            tick(1);
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL fill_seq: %0d bad cycles, first at index %0d, want 0", errs, first);
        end
        total++;
        if (coef_we !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL fill_end: we=%b busy=%b want 0 0", coef_we, busy);
        end
        total++;
        if (cmd_count !== 16'd2) begin
            bad++;
            $display("FAIL fill_count: cmd=%0d want 2", cmd_count);
        end
        tick(4);
        total++;
        if (coef_we !== 1'b0 || cmd_count !== 16'd2) begin
            bad++;
            $display("FAIL fill_no_extra: we=%b cmd=%0d want 0 2", coef_we, cmd_count);
        end
        ctl_in = 32'h0;
        tick(3);
    endtask

    task automatic test_commit_swap();
        ctl_in = 32'h2000_0000;
        tick(3);
        total++;
        if (busy !== 1'b1 || active_bank !== 1'b0) begin
            bad++;
            $display("FAIL commit_pending: busy=%b active=%b want 1 0", busy, active_bank);
        end
        tick(7);
        sync_in = 1'b1;
        tick(1);
        sync_in = 1'b0;
        total++;
        if (active_bank !== 1'b1 || coef_bank !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL commit_swap: active=%b coef_bank=%b busy=%b want 1 0 1",
                     active_bank, coef_bank, busy);
        end
        tick(1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL commit_busy: busy=%b want 0", busy);
        end
        ctl_in = 32'h0;
        tick(3);
    endtask

    task automatic test_commit_during_fill();
        int errs = 0;
        int first = -1;
        ctl_in = 32'hC000_0033;
        tick(3);
        for (int i = 0; i < 1024; i++) begin
            if (i == 100) ctl_in = 32'h2000_0000;
            if (i == 101) ctl_in = 32'h0;
            sync_in = (i == 500);
            if (coef_we !== 1'b1 || coef_addr !== i[9:0] || coef_data !== 16'h0033
                || active_bank !== 1'b1 || coef_bank !== 1'b0) begin
                errs++;
                if (first < 0) first = i;
            end
            tick(1);
        end
        sync_in = 1'b0;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL cfill_seq: %0d bad cycles, first at index %0d, want 0", errs, first);
        end
        total++;
        if (active_bank !== 1'b1 || busy !== 1'b1 || cmd_count !== 16'd3) begin
            bad++;
            $display("FAIL cfill_end: active=%b busy=%b cmd=%0d want 1 1 3",
                     active_bank, busy, cmd_count);
        end
        sync_in = 1'b1;
        tick(1);
        sync_in = 1'b0;
        total++;
        if (active_bank !== 1'b0 || coef_bank !== 1'b1) begin
            bad++;
            $display("FAIL cfill_swap: active=%b coef_bank=%b want 0 1", active_bank, coef_bank);
        end
        tick(3);
    endtask

    // Write strobe and sync land in the same idle cycle with a commit pending.
    task automatic test_back_to_back();
        ctl_in = 32'h2000_0000;
        tick(3);
        ctl_in = 32'h0;
        tick(2);
        ctl_in = 32'h8007_00BB;
        tick(1);
        sync_in = 1'b1;
        tick(1);
        sync_in = 1'b0;
        total++;
        if (active_bank !== 1'b1) begin
            bad++;
            $display("FAIL b2b_swap: active=%b want 1", active_bank);
        end
        tick(1);
        total++;
        if (coef_we !== 1'b1 || coef_addr !== 10'h007 || coef_data !== 16'h00BB
            || coef_bank !== 1'b0 || cmd_count !== 16'd4) begin
            bad++;
            $display("FAIL b2b_write: we=%b addr=%h data=%h bank=%b cmd=%0d want 1 007 00bb 0 4",
                     coef_we, coef_addr, coef_data, coef_bank, cmd_count);
        end
        ctl_in = 32'h0;
        tick(3);
    endtask

    task automatic test_reset_mid_fill();
        ctl_in = 32'hC000_0011;
        tick(303);
        total++;
        if (coef_we !== 1'b1 || coef_addr !== 10'd300) begin
            bad++;
            $display("FAIL rfill_pos: we=%b addr=%0d want 1 300", coef_we, coef_addr);
        end
        user_rst_n = 1'b0;
        tick(1);
        user_rst_n = 1'b1;
        total++;
        if (coef_we !== 1'b0 || cmd_count !== 16'd0 || active_bank !== 1'b0
            || busy !== 1'b0) begin
            bad++;
            $display("FAIL rfill_abort: we=%b cmd=%0d active=%b busy=%b want 0 0 0 0",
                     coef_we, cmd_count, active_bank, busy);
        end
        tick(2);
        total++;
        if (coef_we !== 1'b0) begin
            bad++;
            $display("FAIL rfill_restart_early: we=%b want 0", coef_we);
        end
        tick(1);
        total++;
        if (coef_we !== 1'b1 || coef_addr !== 10'd0 || coef_data !== 16'h0011) begin
            bad++;
            $display("FAIL rfill_restart: we=%b addr=%0d data=%h want 1 0 0011",
                     coef_we, coef_addr, coef_data);
        end
        user_rst_n = 1'b0;
        ctl_in = 32'h0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_ignored();
        test_commit_swap();
        test_commit_during_fill();
        test_back_to_back();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
